// File: rtl/pdp11_fetch_pkg.sv
// pdp11_fetch_pkg: shared states, instruction types, reset default and predecode for the PDP-11 fetch unit
package pdp11_fetch_pkg;
  localparam logic [15:0] RESET_PC_DEFAULT = 16'o000000;
  typedef enum logic [1:0] {BOOT, RUN, HALTED} fetch_state_t;
  typedef enum logic [1:0] {SINGLE_OPERAND, DOUBLE_OPERAND_1, DOUBLE_OPERAND_2, CONDITIONAL_BRANCH} instruction_type_t;
  function automatic instruction_type_t predecode(input logic [15:0] w);
    return (w[15:12] inside {[4'd1:4'd6], [4'd9:4'd14]}) ? DOUBLE_OPERAND_1 :
      (w[15:12] == 4'd7) ? DOUBLE_OPERAND_2 :
      (w[15:8] inside {[8'h01:8'h07], [8'h80:8'h87]}) ? CONDITIONAL_BRANCH : SINGLE_OPERAND;
  endfunction
endpackage

// File: rtl/pdp11_fetch_buffer.sv
// pdp11_fetch_buffer: two-entry prefetch FIFO with push, pop and flush
module pdp11_fetch_buffer #(
  parameter int W = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  logic [W-1:0] mem [2];
  logic         rd;
  logic         wr;
  logic [1:0]   cnt;
  assign dout  = mem[rd];
  assign full  = cnt == 2'd2;
  assign empty = cnt == 2'd0;
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      rd  <= 1'b0;
      wr  <= 1'b0;
      cnt <= 2'd0;
    end else begin
      if (push) begin
        mem[wr] <= din;
        wr      <= ~wr;
      end
      if (pop) rd <= ~rd;
      cnt <= cnt + 2'(push) - 2'(pop);
    end
  end
endmodule

// File: rtl/pdp11_fetch.sv
// pdp11_fetch: PDP-11 instruction prefetch unit; define FETCH_ODD_ADDR_TRAP_EN to trap odd redirect targets
module pdp11_fetch
  import pdp11_fetch_pkg::*;
#(
  parameter logic [15:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset,
  output logic        flash_rd,
  output logic [14:0] flash_addr,
  input  logic [15:0] flash_data,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  input  logic        halt,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [15:0] instr_word,
  output logic [15:0] instr_pc,
  output logic [1:0]  instr_type,
  output logic        odd_addr_err
);
  fetch_state_t state;
  fetch_state_t state_nxt;
  logic [15:0]  pc;
  logic         in_flight;
  logic         err;
  logic         trap;
  logic         pop;
  logic         push;
  logic         full;
  logic         empty;
  logic         room;
  logic [31:0]  head;
`ifdef FETCH_ODD_ADDR_TRAP_EN
  assign trap = redirect_valid && redirect_pc[0];
`else
  assign trap = 1'b0;
`endif
  assign odd_addr_err = err;
  assign room = int'({full, !full && !empty}) + int'(in_flight) < BUF_DEPTH + int'(pop);
  assign flash_rd = !reset && state == RUN && !halt && !redirect_valid && room;
  assign flash_addr = pc[15:1];
  assign instr_valid = !reset && !redirect_valid && !empty;
  assign pop = instr_valid && instr_ready;
  assign push = in_flight && !redirect_valid;
  assign {instr_word, instr_pc} = head;
  assign instr_type = predecode(instr_word);
  pdp11_fetch_buffer #(.W(32)) buffer (
    .clock(clock),
    .reset(reset),
    .flush(redirect_valid),
    .push(push),
    .pop(pop),
    .din({flash_data, pc - 16'd2}),
    .dout(head),
    .full(full),
    .empty(empty)
  );
  always_comb state_nxt = (trap || err) ? HALTED : state == BOOT ? RUN : redirect_valid ? state : halt ? HALTED : RUN;
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= BOOT;
      pc        <= RESET_PC;
      in_flight <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_nxt;
      in_flight <= flash_rd;
      err       <= err || trap;
      pc        <= redirect_valid ? (redirect_pc & 16'hfffe) : pc + {14'd0, flash_rd, 1'b0};
    end
  end
endmodule

// File: tb/tb_pdp11_fetch.sv
// tb_pdp11_fetch: directed tests plus a stream-level reference model checked every cycle
module tb_pdp11_fetch;
  import pdp11_fetch_pkg::*;
  logic        clock = 0;
  logic        reset;
  logic        flash_rd;
  logic [14:0] flash_addr;
  logic [15:0] flash_data = 16'hdead;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        halt;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr_word;
  logic [15:0] instr_pc;
  logic [1:0]  instr_type;
  logic        odd_addr_err;
  int checks = 0;
  int errors = 0;
  logic [15:0] m_pc, m_rd, p_pc, p_word;
  logic        m_hold, accept;
  int          m_out;
  logic [15:0] t1_word [4] = '{16'o010203, 16'o000401, 16'o070001, 16'o005000};
  logic [1:0]  t1_type [4] = '{DOUBLE_OPERAND_1, CONDITIONAL_BRANCH, DOUBLE_OPERAND_2, SINGLE_OPERAND};
  logic [15:0] drained [$];
  int          n_rd;
  pdp11_fetch dut (
    .clock(clock),
    .reset(reset),
    .flash_rd(flash_rd),
    .flash_addr(flash_addr),
    .flash_data(flash_data),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .halt(halt),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instr_word(instr_word),
    .instr_pc(instr_pc),
    .instr_type(instr_type),
    .odd_addr_err(odd_addr_err)
  );
  always #5 clock = ~clock;
  function automatic logic [15:0] flash_word(input logic [14:0] a);
    case (a)
      15'd0: return 16'o010203;
      15'd1: return 16'o000401;
      15'd2: return 16'o070001;
      15'd3: return 16'o005000;
      default: return {a[3:0], a[14:3]} ^ 16'h3c5a;
    endcase
  endfunction
  function automatic logic [1:0] model_type(input logic [15:0] w);
    int op = int'(w[15:12]);
    int hi = int'(w[15:8]);
    if (op == 7) return DOUBLE_OPERAND_2;
    if (op != 0 && op != 8 && op != 15) return DOUBLE_OPERAND_1;
    if ((hi >= 1 && hi <= 7) || (hi >= 128 && hi <= 135)) return CONDITIONAL_BRANCH;
    return SINGLE_OPERAND;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clock);
    #1;
  endtask
  task automatic do_reset();
    reset = 1;
    redirect_valid = 0;
    redirect_pc = 0;
    halt = 0;
    instr_ready = 1;
    repeat (2) @(posedge clock);
    #1 reset = 0;
  endtask
  task automatic next_accept(input string name, input logic [15:0] exp);
    bit got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clock);
      if (instr_valid && instr_ready) begin
        chk(name, instr_pc, exp);
        got = 1;
      end
      step();
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL %s: no word accepted in 20 cycles, expected pc %0h", name, exp);
    end
  endtask
  always @(posedge clock) flash_data <= flash_rd ? flash_word(flash_addr) : 16'hdead;
  always @(negedge clock) begin
    if (reset) begin
      chk("rst_flash_rd", flash_rd, 0);
      chk("rst_instr_valid", instr_valid, 0);
      m_pc = 16'o000000;
      m_rd = 16'o000000;
      m_out = 0;
      m_hold = 0;
    end else begin
      if (redirect_valid) chk("redirect_valid_gate", instr_valid, 0);
      if (halt || redirect_valid) chk("rd_gate", flash_rd, 0);
      if (m_hold && !redirect_valid) begin
        chk("hold_valid", instr_valid, 1);
        chk("hold_pc", instr_pc, p_pc);
        chk("hold_word", instr_word, p_word);
      end
      if (flash_rd) begin
        chk("rd_addr", flash_addr, m_rd[15:1]);
        m_rd = m_rd + 16'd2;
      end
      if (instr_valid) begin
        chk("stream_pc", instr_pc, m_pc);
        chk("stream_word", instr_word, flash_word(m_pc[15:1]));
        chk("stream_type", instr_type, model_type(flash_word(m_pc[15:1])));
      end
      accept = instr_valid && instr_ready;
      if (accept) m_pc = m_pc + 16'd2;
      m_out = m_out + int'(flash_rd) - int'(accept);
      chk("occupancy", m_out <= 2, 1);
      m_hold = instr_valid && !instr_ready;
      p_pc = instr_pc;
      p_word = instr_word;
      if (redirect_valid) begin
        m_pc = redirect_pc & 16'hfffe;
        m_rd = redirect_pc & 16'hfffe;
        m_out = 0;
        m_hold = 0;
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at 200000, expected finish");
    $fatal(1);
  end
  initial begin
    do_reset();
    for (int k = 0; k < 7; k++) begin
      @(negedge clock);
      if (k == 0) chk("t1_boot_rd", flash_rd, 0);
      if (k == 1) begin
        chk("t1_first_rd", flash_rd, 1);
        chk("t1_first_addr", flash_addr, 0);
      end
      chk("t1_valid", instr_valid, k >= 3);
      if (k >= 3) begin
        chk("t1_pc", instr_pc, 2 * (k - 3));
        chk("t1_word", instr_word, t1_word[k-3]);
        chk("t1_type", instr_type, t1_type[k-3]);
      end
      step();
    end
    do_reset();
    instr_ready = 0;
    n_rd = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      n_rd += int'(flash_rd);
      if (k >= 3) begin
        chk("t2_valid", instr_valid, 1);
        chk("t2_pc", instr_pc, 0);
        chk("t2_word", instr_word, 16'o010203);
      end
      step();
    end
    chk("t2_reads", n_rd, 2);
    instr_ready = 1;
    for (int i = 0; i < 4; i++) next_accept("t2_release", 16'(2 * i));
    do_reset();
    instr_ready = 0;
    repeat (3) step();
    redirect_valid = 1;
    redirect_pc = 16'o001000;
    @(negedge clock);
    chk("t3_valid", instr_valid, 0);
    chk("t3_rd", flash_rd, 0);
    step();
    redirect_valid = 0;
    instr_ready = 1;
    @(negedge clock);
    chk("t3_new_rd", flash_rd, 1);
    chk("t3_new_addr", flash_addr, 15'o000400);
    step();
    next_accept("t3_first", 16'o001000);
    next_accept("t3_second", 16'o001002);
    do_reset();
    repeat (5) step();
    halt = 1;
    drained.delete();
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      chk("t4_halt_rd", flash_rd, 0);
      if (instr_valid && instr_ready) drained.push_back(instr_pc);
      step();
    end
    halt = 0;
    chk("t4_drained", drained.size(), 2);
    if (drained.size() == 2) begin
      chk("t4_drain0", drained[0], 4);
      chk("t4_drain1", drained[1], 6);
    end
    next_accept("t4_resume", 16'o000010);
    do_reset();
    repeat (2) step();
    redirect_valid = 1;
    redirect_pc = 16'o177776;
    step();
    redirect_valid = 0;
    next_accept("t5_top", 16'o177776);
    next_accept("t5_wrap", 16'o000000);
    do_reset();
    halt = 1;
    repeat (3) step();
    redirect_valid = 1;
    redirect_pc = 16'o002000;
    step();
    redirect_valid = 0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clock);
      chk("t7_halted_rd", flash_rd, 0);
      step();
    end
    halt = 0;
    next_accept("t7_redirect_halted", 16'o002000);
    do_reset();
    repeat (4) step();
    redirect_valid = 1;
    redirect_pc = 16'o001001;
    step();
    redirect_valid = 0;
`ifdef FETCH_ODD_ADDR_TRAP_EN
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      chk("t6_err", odd_addr_err, 1);
      chk("t6_trap_rd", flash_rd, 0);
      chk("t6_trap_valid", instr_valid, 0);
      step();
    end
    do_reset();
    @(negedge clock);
    chk("t6_err_cleared", odd_addr_err, 0);
    step();
    next_accept("t6_after_reset", 16'o000000);
`else
    @(negedge clock);
    chk("t6_err_tied", odd_addr_err, 0);
    step();
    next_accept("t6_even", 16'o001000);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
